// File: rtl/calc_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calc_request_sequencer
// Description : Client-side front end for a combinational 64-bit calculator.
//               Accepts tagged requests, launches registered operands, samples
//               the result after a fixed settle latency, flags illegal ops and
//               returns tagged responses through a show-ahead response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_request_sequencer #(
    parameter int WIDTH      = 64,
    parameter int CALC_LAT   = 1,
    parameter int RESP_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_mode,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] calc_a,
    output logic [WIDTH-1:0] calc_b,
    output logic [3:0]       calc_mode,
    input  logic [WIDTH-1:0] calc_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);

    localparam int c_PTR_W = (RESP_DEPTH > 2) ? $clog2(RESP_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RESP_DEPTH);
    localparam logic [3:0]         c_LAT   = 4'(CALC_LAT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [3:0]         r_wait_cnt;
    logic [TAG_W-1:0]   r_tag;
    logic               r_err;
    logic [WIDTH-1:0]   r_calc_a;
    logic [WIDTH-1:0]   r_calc_b;
    logic [3:0]         r_calc_mode;

    logic               w_req_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_err;

    logic [WIDTH-1:0]   r_mem_result [RESP_DEPTH];
    logic [TAG_W-1:0]   r_mem_tag    [RESP_DEPTH];
    logic               r_mem_err    [RESP_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Illegal: unknown mode, or divide by zero.
    assign w_err    = (req_mode > 4'd3) || ((req_mode == 4'd3) && (req_b == '0));
    assign w_accept = req_valid && w_req_ready;
    assign w_pop    = (r_count != '0) && rsp_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: one operation in flight, back to IDLE once the result lands.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_WAIT;
            S_WAIT:  if (r_wait_cnt == 4'd1) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: acceptance gated on FIFO room (held low during reset),
    // push on the final wait cycle.
    always_comb begin
        w_req_ready = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE:  w_req_ready = rst_n && (r_count < c_DEPTH);
            S_WAIT:  w_push      = (r_wait_cnt == 4'd1);
            default: ;
        endcase
    end

    // Operand launch, tag/error capture and settle countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_calc_a    <= '0;
            r_calc_b    <= '0;
            r_calc_mode <= '0;
            r_tag       <= '0;
            r_err       <= 1'b0;
            r_wait_cnt  <= '0;
        end else if (w_accept) begin
            r_calc_a    <= req_a;
            r_calc_b    <= req_b;
            r_calc_mode <= req_mode;
            r_tag       <= req_tag;
            r_err       <= w_err;
            r_wait_cnt  <= c_LAT;
        end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
            r_wait_cnt  <= r_wait_cnt - 4'd1;
        end
    end

    // Response FIFO storage; illegal ops return a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                r_mem_result[i] <= '0;
                r_mem_tag[i]    <= '0;
                r_mem_err[i]    <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_result[r_wr_ptr] <= r_err ? '0 : calc_result;
            r_mem_tag[r_wr_ptr]    <= r_tag;
            r_mem_err[r_wr_ptr]    <= r_err;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign calc_a     = r_calc_a;
    assign calc_b     = r_calc_b;
    assign calc_mode  = r_calc_mode;
    assign rsp_valid  = (r_count != '0);
    assign rsp_result = r_mem_result[r_rd_ptr];
    assign rsp_tag    = r_mem_tag[r_rd_ptr];
    assign rsp_err    = r_mem_err[r_rd_ptr];
    assign busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_calc_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_request_sequencer
// Description : Directed self-checking bench; one instance at CALC_LAT=1 and
//               one at CALC_LAT=3, each driving a behavioural calculator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_request_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Calculator stand-in; div-by-zero and unknown modes return non-zero
    // junk so that the sequencer's zero forcing is visible.
    function automatic logic [63:0] calc_fn(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] m);
        case (m)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            default: return 64'h0000_0000_0000_DEAD;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- instance 1 (CALC_LAT = 1) ----------------
    logic        rst_n1 = 1'b0, req_valid1 = 1'b0, rsp_ready1 = 1'b1;
    logic        req_ready1, rsp_valid1, rsp_err1, busy1;
    logic [63:0] req_a1 = '0, req_b1 = '0, calc_a1, calc_b1, calc_result1, rsp_result1;
    logic [3:0]  req_mode1 = '0, req_tag1 = '0, calc_mode1, rsp_tag1;

    always_comb calc_result1 = calc_fn(calc_a1, calc_b1, calc_mode1);

    calc_request_sequencer #(.WIDTH(64), .CALC_LAT(1), .RESP_DEPTH(4), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1), .req_mode(req_mode1), .req_tag(req_tag1),
        .calc_a(calc_a1), .calc_b(calc_b1), .calc_mode(calc_mode1), .calc_result(calc_result1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_result(rsp_result1),
        .rsp_tag(rsp_tag1), .rsp_err(rsp_err1), .busy(busy1)
    );

    // ---------------- instance 3 (CALC_LAT = 3) ----------------
    logic        rst_n3 = 1'b0, req_valid3 = 1'b0, rsp_ready3 = 1'b1;
    logic        req_ready3, rsp_valid3, rsp_err3, busy3;
    logic [63:0] req_a3 = '0, req_b3 = '0, calc_a3, calc_b3, calc_result3, rsp_result3;
    logic [3:0]  req_mode3 = '0, req_tag3 = '0, calc_mode3, rsp_tag3;

    always_comb calc_result3 = calc_fn(calc_a3, calc_b3, calc_mode3);

    calc_request_sequencer #(.WIDTH(64), .CALC_LAT(3), .RESP_DEPTH(4), .TAG_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_mode(req_mode3), .req_tag(req_tag3),
        .calc_a(calc_a3), .calc_b(calc_b3), .calc_mode(calc_mode3), .calc_result(calc_result3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
        .rsp_tag(rsp_tag3), .rsp_err(rsp_err3), .busy(busy3)
    );

    task automatic drv1(input logic [63:0] a, input logic [63:0] b, input logic [3:0] m,
                        input logic [3:0] t);
        req_valid1 = 1'b1; req_a1 = a; req_b1 = b; req_mode1 = m; req_tag1 = t;
    endtask

    task automatic drv3(input logic [63:0] a, input logic [63:0] b, input logic [3:0] m,
                        input logic [3:0] t);
        req_valid3 = 1'b1; req_a3 = a; req_b3 = b; req_mode3 = m; req_tag3 = t;
    endtask

    task automatic wait_ready1(input string tag);
        int n = 0;
        while (!req_ready1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, req_ready1}, 64'd1);
    endtask

    // Back-to-back vectors: sub, mul, div, add-with-wrap.
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic [3:0]  vm [4];
    logic [3:0]  vt [4];
    logic [63:0] vr [4];

    initial begin
        va[0] = 64'd10;  vb[0] = 64'd3; vm[0] = 4'd1; vt[0] = 4'd1; vr[0] = 64'd7;
        va[1] = 64'd6;   vb[1] = 64'd7; vm[1] = 4'd2; vt[1] = 4'd2; vr[1] = 64'd42;
        va[2] = 64'd100; vb[2] = 64'd4; vm[2] = 4'd3; vt[2] = 4'd4; vr[2] = 64'd25;
        va[3] = 64'hFFFF_FFFF_FFFF_FFFF; vb[3] = 64'd1; vm[3] = 4'd0; vt[3] = 4'd5; vr[3] = 64'd0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready1}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid1}, 64'd0);
        chk("rst_busy",      {63'd0, busy1},      64'd0);
        chk("rst_calc_a",    calc_a1,             64'd0);
        chk("rst_calc_mode", {60'd0, calc_mode1}, 64'd0);
        chk("rst_rsp_result", rsp_result1,        64'd0);
        rst_n1 = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, req_ready1}, 64'd1);

        // ---- 1: single add ----
        drv1(64'd5, 64'd7, 4'd0, 4'd3);
        @(negedge clk);
        chk("t1_ready_lo",  {63'd0, req_ready1}, 64'd0);
        chk("t1_calc_a",    calc_a1,             64'd5);
        chk("t1_busy",      {63'd0, busy1},      64'd1);
        chk("t1_rsp_early", {63'd0, rsp_valid1}, 64'd0);
        req_valid1 = 1'b0;
        @(negedge clk);
        chk("t1_rsp_valid",  {63'd0, rsp_valid1}, 64'd1);
        chk("t1_rsp_result", rsp_result1,         64'd12);
        chk("t1_rsp_tag",    {60'd0, rsp_tag1},   64'd3);
        chk("t1_rsp_err",    {63'd0, rsp_err1},   64'd0);
        chk("t1_ready_back", {63'd0, req_ready1}, 64'd1);
        @(negedge clk);
        chk("t1_rsp_gone",   {63'd0, rsp_valid1}, 64'd0);
        chk("t1_idle",       {63'd0, busy1},      64'd0);

        // ---- 2: back-to-back, request held valid ----
        drv1(va[0], vb[0], vm[0], vt[0]);
        for (int i = 0; i < 4; i++) begin
            chk("t2_ready_hi", {63'd0, req_ready1}, 64'd1);
            if (i > 0) begin
                chk("t2_rsp_valid",  {63'd0, rsp_valid1}, 64'd1);
                chk("t2_rsp_result", rsp_result1,         vr[i-1]);
                chk("t2_rsp_tag",    {60'd0, rsp_tag1},   {60'd0, vt[i-1]});
            end
            @(negedge clk);
            chk("t2_ready_lo", {63'd0, req_ready1}, 64'd0);
            if (i < 3) drv1(va[i+1], vb[i+1], vm[i+1], vt[i+1]);
            else       req_valid1 = 1'b0;
            @(negedge clk);
        end
        chk("t2_last_valid",  {63'd0, rsp_valid1}, 64'd1);
        chk("t2_last_result", rsp_result1,         64'd0);
        chk("t2_last_tag",    {60'd0, rsp_tag1},   64'd5);
        @(negedge clk);
        chk("t2_drained",     {63'd0, rsp_valid1}, 64'd0);

        // ---- 3: illegal operations ----
        drv1(64'd9, 64'd0, 4'd3, 4'd6);
        @(negedge clk);
        chk("t3_div0_mode", {60'd0, calc_mode1}, 64'd3);
        chk("t3_div0_b",    calc_b1,             64'd0);
        req_valid1 = 1'b0;
        @(negedge clk);
        chk("t3_div0_valid",  {63'd0, rsp_valid1}, 64'd1);
        chk("t3_div0_err",    {63'd0, rsp_err1},   64'd1);
        chk("t3_div0_result", rsp_result1,         64'd0);
        chk("t3_div0_tag",    {60'd0, rsp_tag1},   64'd6);
        drv1(64'd1, 64'd2, 4'd4, 4'd7);
        @(negedge clk);
        chk("t3_m4_mode", {60'd0, calc_mode1}, 64'd4);
        req_valid1 = 1'b0;
        @(negedge clk);
        chk("t3_m4_valid",  {63'd0, rsp_valid1}, 64'd1);
        chk("t3_m4_err",    {63'd0, rsp_err1},   64'd1);
        chk("t3_m4_result", rsp_result1,         64'd0);
        chk("t3_m4_tag",    {60'd0, rsp_tag1},   64'd7);
        @(negedge clk);
        chk("t3_drained",   {63'd0, rsp_valid1}, 64'd0);
        rsp_ready1 = 1'b0;

        // ---- 4: back-pressure fills the FIFO ----
        for (int i = 0; i < 4; i++) begin
            wait_ready1("t4_accept_wait");
            drv1(64'(i), 64'd10, 4'd0, 4'(8 + i));
            @(negedge clk);
        end
        drv1(64'd4, 64'd10, 4'd0, 4'd12);
        repeat (4) begin
            @(negedge clk);
            chk("t4_full_ready", {63'd0, req_ready1}, 64'd0);
            chk("t4_head_valid", {63'd0, rsp_valid1}, 64'd1);
            chk("t4_head_tag",   {60'd0, rsp_tag1},   64'd8);
            chk("t4_head_res",   rsp_result1,         64'd10);
        end
        rsp_ready1 = 1'b1;
        @(negedge clk);
        rsp_ready1 = 1'b0;
        chk("t4_room_ready", {63'd0, req_ready1}, 64'd1);
        chk("t4_new_head",   {60'd0, rsp_tag1},   64'd9);
        @(negedge clk);
        chk("t4_fifth_taken", {63'd0, req_ready1}, 64'd0);
        req_valid1 = 1'b0;
        @(negedge clk);
        rsp_ready1 = 1'b1;
        for (int j = 1; j < 5; j++) begin
            chk("t4_drain_valid",  {63'd0, rsp_valid1}, 64'd1);
            chk("t4_drain_tag",    {60'd0, rsp_tag1},   64'(8 + j));
            chk("t4_drain_result", rsp_result1,         64'(10 + j));
            @(negedge clk);
        end
        chk("t4_empty", {63'd0, rsp_valid1}, 64'd0);
        chk("t4_idle",  {63'd0, busy1},      64'd0);

        // ---- 6: CALC_LAT = 3, single mul ----
        rst_n3 = 1'b1;
        @(negedge clk);
        chk("t6_ready", {63'd0, req_ready3}, 64'd1);
        drv3(64'd3, 64'd4, 4'd2, 4'd2);
        @(negedge clk);
        req_valid3 = 1'b0;
        repeat (3) begin
            chk("t6_ready_lo", {63'd0, req_ready3}, 64'd0);
            chk("t6_no_rsp",   {63'd0, rsp_valid3}, 64'd0);
            @(negedge clk);
        end
        chk("t6_rsp_valid",  {63'd0, rsp_valid3}, 64'd1);
        chk("t6_rsp_result", rsp_result3,         64'd12);
        chk("t6_rsp_tag",    {60'd0, rsp_tag3},   64'd2);
        chk("t6_ready_back", {63'd0, req_ready3}, 64'd1);
        @(negedge clk);

        // ---- 5: reset while waiting ----
        drv3(64'd1, 64'd1, 4'd0, 4'd9);
        @(negedge clk);
        req_valid3 = 1'b0;
        chk("t5_busy_before", {63'd0, busy3}, 64'd1);
        rst_n3 = 1'b0;
        #1;
        chk("t5_rst_busy",   {63'd0, busy3},      64'd0);
        chk("t5_rst_calc_a", calc_a3,             64'd0);
        chk("t5_rst_calc_b", calc_b3,             64'd0);
        chk("t5_rst_ready",  {63'd0, req_ready3}, 64'd0);
        @(negedge clk);
        rst_n3 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t5_no_rsp", {63'd0, rsp_valid3}, 64'd0);
        end
        chk("t5_ready", {63'd0, req_ready3}, 64'd1);
        drv3(64'd20, 64'd5, 4'd1, 4'd4);
        @(negedge clk);
        req_valid3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_after_valid",  {63'd0, rsp_valid3}, 64'd1);
        chk("t5_after_result", rsp_result3,         64'd15);
        chk("t5_after_tag",    {60'd0, rsp_tag3},   64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
